// File: rtl/clock_gate_cell.sv
// rtl/clock_gate_cell.sv - latch-based glitch-free clock gate with hold-off, test override and activity counters
`timescale 1ns/1ps

module clock_gate_cell #(
    parameter int HOLD_CYCLES = 0,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 test_en,
    input  logic                 stat_clr,
    output logic                 gclk,
    output logic                 gate_open,
    output logic [CNT_WIDTH-1:0] active_cycles,
    output logic [CNT_WIDTH-1:0] total_cycles
);

    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [HW-1:0]        HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    logic [HW-1:0] hold_cnt;
    logic          eff_en;
    logic          en_lat;

    assign eff_en = enable | test_en | (hold_cnt != '0);

    // Transparent only while clk is low, so enable changes in the high phase cannot split a pulse.
    always_latch begin
        if (!rst_n)
            en_lat <= 1'b0;
        else if (!clk)
            en_lat <= eff_en;
    end

    assign gclk      = clk & en_lat;
    assign gate_open = en_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hold_cnt <= '0;
        else if (enable)
            hold_cnt <= HOLD_LOAD;
        else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - HW'(1);
    end

    // en_lat is closed during the high phase, so it reflects whether this edge reached gclk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cycles  <= '0;
            active_cycles <= '0;
        end else if (stat_clr) begin
            total_cycles  <= '0;
            active_cycles <= '0;
        end else begin
            if (total_cycles != CNT_MAX)
                total_cycles <= total_cycles + CNT_WIDTH'(1);
            if (en_lat && (active_cycles != CNT_MAX))
                active_cycles <= active_cycles + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_clock_gate_cell.sv
// tb/tb_clock_gate_cell.sv - directed self-checking bench for clock_gate_cell
`timescale 1ns/1ps

module tb_clock_gate_cell;

    logic clk, rst_n, enable, test_en, stat_clr;

    logic        gclk0, gate_open0;
    logic [31:0] act0, tot0;
    logic        gclk3, gate_open3;
    logic [31:0] act3, tot3;
    logic        gclks, gate_opens;
    logic [3:0]  acts, tots;

    clock_gate_cell #(.HOLD_CYCLES(0), .CNT_WIDTH(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .test_en(test_en), .stat_clr(stat_clr),
        .gclk(gclk0), .gate_open(gate_open0), .active_cycles(act0), .total_cycles(tot0));

    clock_gate_cell #(.HOLD_CYCLES(3), .CNT_WIDTH(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .test_en(test_en), .stat_clr(stat_clr),
        .gclk(gclk3), .gate_open(gate_open3), .active_cycles(act3), .total_cycles(tot3));

    clock_gate_cell #(.HOLD_CYCLES(0), .CNT_WIDTH(4)) u_duts (
        .clk(clk), .rst_n(rst_n), .enable(enable), .test_en(test_en), .stat_clr(stat_clr),
        .gclk(gclks), .gate_open(gate_opens), .active_cycles(acts), .total_cycles(tots));

    int tests_run = 0;
    int tests_failed = 0;

    int  p0 = 0, p3 = 0, spur0 = 0, bad_w0 = 0;
    time rise0 = 0;
    int  b0, b3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge gclk0) begin
        p0++;
        rise0 = $time;
        if (!clk) spur0++;
    end

    // Pulses cut short by reset are allowed; only judge widths outside reset.
    always @(negedge gclk0) begin
        if (rst_n && (($time - rise0) != 5)) bad_w0++;
    end

    always @(posedge gclk3) p3++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cleanup();
        enable  = 1'b0;
        test_en = 1'b0;
        repeat (6) @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        b0 = p0;
        b3 = p3;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; test_en = 1'b0; stat_clr = 1'b0;

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_gclk_high", gclk0, 0);
        end
        @(negedge clk);
        check("rst_gate_open", gate_open0, 0);
        check("rst_active", act0, 0);
        check("rst_total", tot0, 0);
        check("rst_pulses", p0, 0);

        rst_n = 1'b1;
        b0 = p0;
        #1;
        check("rel_gate_open", gate_open0, 1);
        @(posedge clk); #1;
        check("rel_first_gclk", gclk0, 1);
        check("rel_first_pulse", p0 - b0, 1);
        @(negedge clk);

        cleanup();
        enable = 1'b1;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("basic_pulses", p0 - b0, 10);
        check("basic_active", act0, 10);
        check("basic_total", tot0, 15);
        check("basic_gate_closed", gate_open0, 0);
        check("basic_h3_pulses", p3 - b3, 13);
        check("basic_h3_active", act3, 13);
        check("basic_w4_total", tots, 15);

        cleanup();
        @(posedge clk); #1;
        enable = 1'b1;
        #2;
        check("glitch_closed_high", gclk0, 0);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        #2;
        enable = 1'b1;
        #1;
        check("glitch_open_high", gclk0, 1);
        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("glitch_pulses", p0 - b0, 1);
        check("glitch_widths", bad_w0, 0);
        check("glitch_spurious", spur0, 0);

        cleanup();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_pulses_4", p3 - b3, 4);
        check("hold_gate_closed", gate_open3, 0);
        @(negedge clk);
        check("hold_5th_blocked", p3 - b3, 4);
        check("hold_h0_pulses", p0 - b0, 1);

        cleanup();
        test_en = 1'b1;
        repeat (8) @(negedge clk);
        test_en = 1'b0;
        @(negedge clk);
        check("test_pulses", p0 - b0, 8);
        check("test_active", act0, 8);
        check("test_h3_active", act3, 8);

        test_en = 1'b1;
        @(posedge clk); #1;
        check("test_gclk_on", gclk0, 1);
        rst_n = 1'b0;
        #1;
        check("test_rst_drop", gclk0, 0);
        check("test_rst_gate", gate_open0, 0);
        @(posedge clk); #1;
        check("test_rst_hold", gclk0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        test_en = 1'b0;

        cleanup();
        enable = 1'b1;
        repeat (20) @(negedge clk);
        check("sat_active", acts, 15);
        check("sat_total", tots, 15);
        check("sat_wide_active", act0, 20);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("clr_active", acts, 0);
        check("clr_total", tots, 0);
        @(negedge clk);
        check("resume_active", acts, 1);
        check("resume_total", tots, 1);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
